// File: rtl/sensor_sequence_decoder.sv
// Optical two-beam crossing decoder: synchronises and debounces a/b, then
// tracks the beam sequence and emits one-cycle enter/exit/seq_err pulses.
module sensor_sequence_decoder #(
  parameter int DEB_CYCLES = 4,
  parameter int DEB_W      = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic a,
  input  logic b,
  output logic enter,
  output logic exit,
  output logic seq_err,
  output logic busy,
  output logic fa,
  output logic fb
);

  localparam logic [DEB_W-1:0] DEB_MAX = DEB_W'(DEB_CYCLES);

  typedef enum logic [2:0] {
    IDLE, IN1, IN2, IN3, OUT1, OUT2, OUT3, ERR
  } state_t;

  logic [1:0] raw;
  logic [1:0] filt;

  assign raw = {a, b};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_deb
      logic             sync1_reg;
      logic             sync2_reg;
      logic             filt_reg;
      logic [DEB_W-1:0] cnt_reg;
      logic [DEB_W-1:0] cnt_inc;

      assign cnt_inc  = cnt_reg + DEB_W'(1);
      assign filt[gi] = filt_reg;

      // The counter measures how long the synced value has disagreed with filt.
      always_ff @(posedge clk) begin
        if (reset) begin
          sync1_reg <= 1'b0;
          sync2_reg <= 1'b0;
          filt_reg  <= 1'b0;
          cnt_reg   <= '0;
        end else begin
          sync1_reg <= raw[gi];
          sync2_reg <= sync1_reg;
          if (sync2_reg == filt_reg) begin
            cnt_reg <= '0;
          end else if (cnt_inc == DEB_MAX) begin
            filt_reg <= sync2_reg;
            cnt_reg  <= '0;
          end else begin
            cnt_reg <= cnt_inc;
          end
        end
      end
    end
  endgenerate

  assign fa = filt[1];
  assign fb = filt[0];

  state_t state_reg;
  state_t state_next;
  logic   enter_next;
  logic   exit_next;
  logic   err_next;

  always_comb begin
    state_next = state_reg;
    enter_next = 1'b0;
    exit_next  = 1'b0;
    err_next   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (filt == 2'b10)      state_next = IN1;
        else if (filt == 2'b01) state_next = OUT1;
        else if (filt == 2'b11) state_next = ERR;
      end
      IN1: begin
        if (filt == 2'b11)      state_next = IN2;
        else if (filt == 2'b00) state_next = IDLE;
        else if (filt == 2'b01) state_next = ERR;
      end
      IN2: begin
        if (filt == 2'b01)      state_next = IN3;
        else if (filt == 2'b10) state_next = IN1;
        else if (filt == 2'b00) state_next = ERR;
      end
      IN3: begin
        if (filt == 2'b00) begin
          state_next = IDLE;
          enter_next = 1'b1;
        end else if (filt == 2'b11) begin
          state_next = IN2;
        end else if (filt == 2'b10) begin
          state_next = ERR;
        end
      end
      OUT1: begin
        if (filt == 2'b11)      state_next = OUT2;
        else if (filt == 2'b00) state_next = IDLE;
        else if (filt == 2'b10) state_next = ERR;
      end
      OUT2: begin
        if (filt == 2'b10)      state_next = OUT3;
        else if (filt == 2'b01) state_next = OUT1;
        else if (filt == 2'b00) state_next = ERR;
      end
      OUT3: begin
        if (filt == 2'b00) begin
          state_next = IDLE;
          exit_next  = 1'b1;
        end else if (filt == 2'b11) begin
          state_next = OUT2;
        end else if (filt == 2'b01) begin
          state_next = ERR;
        end
      end
      ERR: begin
        if (filt == 2'b00) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    // Only the entry into ERR reports; waiting in ERR stays silent.
    if (state_next == ERR && state_reg != ERR) err_next = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      enter     <= 1'b0;
      exit      <= 1'b0;
      seq_err   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_reg <= state_next;
      enter     <= enter_next;
      exit      <= exit_next;
      seq_err   <= err_next;
      busy      <= (state_next != IDLE);
    end
  end

endmodule

// File: tb/tb_sensor_sequence_decoder.sv
// Bench for sensor_sequence_decoder: behavioural path model checked every cycle,
// plus directed scenarios with hand-computed pulse counts and latencies.
module tb_sensor_sequence_decoder;

  localparam int DEB = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic a = 1'b0;
  logic b = 1'b0;
  logic enter, exit, seq_err, busy, fa, fb;

  int total = 0;
  int bad = 0;
  bit check_en = 1'b0;

  sensor_sequence_decoder #(.DEB_CYCLES(DEB), .DEB_W(16)) dut (
    .clk(clk), .reset(reset), .a(a), .b(b),
    .enter(enter), .exit(exit), .seq_err(seq_err), .busy(busy),
    .fa(fa), .fb(fb)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%b want=%b", name, $time, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%0d want=%0d", name, $time, act, exp);
    end
  endtask

  // Behavioural model: a crossing is a walk along a fixed path of ab codes.
  int fwd [5] = '{0, 2, 3, 1, 0};
  int rev [5] = '{0, 1, 3, 2, 0};

  bit m_s1a = 0, m_s2a = 0, m_s1b = 0, m_s2b = 0;
  bit m_fa = 0, m_fb = 0;
  bit hist_a [$];
  bit hist_b [$];
  int m_dir = 0;
  int m_pos = 0;
  bit m_inerr = 0;
  bit m_enter = 0, m_exit = 0, m_err = 0, m_busy = 0;

  function automatic bit all_differ(input bit q [$], input bit v);
    if (q.size() < DEB) return 1'b0;
    foreach (q[i]) if (q[i] == v) return 1'b0;
    return 1'b1;
  endfunction

  always @(posedge clk) begin : model
    int c;
    int path [5];
    bit sa, sb;
    m_enter = 0; m_exit = 0; m_err = 0;
    if (reset) begin
      m_s1a = 0; m_s2a = 0; m_s1b = 0; m_s2b = 0;
      m_fa = 0; m_fb = 0;
      hist_a.delete(); hist_b.delete();
      m_dir = 0; m_pos = 0; m_inerr = 0; m_busy = 0;
    end else begin
      c = 2 * int'(m_fa) + int'(m_fb);
      if (m_inerr) begin
        if (c == 0) m_inerr = 0;
      end else if (m_dir == 0) begin
        if (c == fwd[1]) begin m_dir = 1; m_pos = 1; end
        else if (c == rev[1]) begin m_dir = 2; m_pos = 1; end
        else if (c != 0) begin m_inerr = 1; m_err = 1; end
      end else begin
        for (int i = 0; i < 5; i++) path[i] = (m_dir == 1) ? fwd[i] : rev[i];
        if (c == path[m_pos]) begin
        end else if (c == path[m_pos+1]) begin
          m_pos++;
          if (m_pos == 4) begin
            if (m_dir == 1) m_enter = 1; else m_exit = 1;
            m_dir = 0; m_pos = 0;
          end
        end else if (c == path[m_pos-1]) begin
          m_pos--;
          if (m_pos == 0) m_dir = 0;
        end else begin
          m_inerr = 1; m_err = 1; m_dir = 0; m_pos = 0;
        end
      end
      m_busy = m_inerr || (m_dir != 0);
      // A filtered value flips once the synced value has opposed it DEB times in a row.
      sa = m_s2a; m_s2a = m_s1a; m_s1a = a;
      sb = m_s2b; m_s2b = m_s1b; m_s1b = b;
      hist_a.push_back(sa); if (hist_a.size() > DEB) void'(hist_a.pop_front());
      hist_b.push_back(sb); if (hist_b.size() > DEB) void'(hist_b.pop_front());
      if (all_differ(hist_a, m_fa)) m_fa = ~m_fa;
      if (all_differ(hist_b, m_fb)) m_fb = ~m_fb;
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      chk("enter", enter, m_enter);
      chk("exit", exit, m_exit);
      chk("seq_err", seq_err, m_err);
      chk("busy", busy, m_busy);
      chk("fa", fa, m_fa);
      chk("fb", fb, m_fb);
    end
  end

  task automatic hold(input logic va, input logic vb, input int n);
    a = va; b = vb;
    repeat (n) @(negedge clk);
  endtask

  task automatic watch(input int cycles, output int n_en, output int n_ex,
                       output int n_er, output int first_en, output int n_fa);
    n_en = 0; n_ex = 0; n_er = 0; first_en = -1; n_fa = 0;
    for (int k = 1; k <= cycles; k++) begin
      @(negedge clk);
      if (enter) begin n_en++; if (first_en < 0) first_en = k; end
      if (exit) n_ex++;
      if (seq_err) n_er++;
      if (fa) n_fa++;
    end
  endtask

  task automatic walk(input bit rev_dir);
    int p;
    int code;
    int steps;
    p = 0; steps = 0;
    hold(0, 0, 8);
    while (p < 4 && steps < 14) begin
      if (p > 0 && $urandom_range(0, 3) == 0) p--; else p++;
      code = rev_dir ? rev[p] : fwd[p];
      hold(code[1], code[0], $urandom_range(7, 10));
      steps++;
    end
    hold(0, 0, 10);
  endtask

  initial begin
    int n_en, n_ex, n_er, first_en, n_fa;
    int code;

    // Reset held three cycles with both beams interrupted.
    reset = 1; a = 1; b = 1;
    @(negedge clk);
    check_en = 1;
    repeat (2) begin
      @(negedge clk);
      chk("rst_fa", fa, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_enter", enter, 1'b0);
    end
    reset = 0;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      chk("rel_fa_latency", fa, (k >= 6) ? 1'b1 : 1'b0);
    end
    chk("model_fa_lit", m_fa, 1'b1);
    hold(0, 0, 20);

    // Forward crossing: enter 7 cycles after the final raw 00 edge.
    hold(1, 0, 10); hold(1, 1, 10); hold(0, 1, 10);
    a = 0; b = 0;
    watch(14, n_en, n_ex, n_er, first_en, n_fa);
    chk_int("fwd_enter_count", n_en, 1);
    chk_int("fwd_enter_delay", first_en, 7);
    chk_int("fwd_exit_count", n_ex, 0);
    chk_int("fwd_err_count", n_er, 0);

    // Reverse crossing.
    hold(0, 1, 10); hold(1, 1, 10); hold(1, 0, 10);
    a = 0; b = 0;
    watch(14, n_en, n_ex, n_er, first_en, n_fa);
    chk_int("rev_exit_count", n_ex, 1);
    chk_int("rev_enter_count", n_en, 0);

    // Aborted entry.
    hold(1, 0, 10); hold(1, 1, 10); hold(1, 0, 10);
    a = 0; b = 0;
    watch(14, n_en, n_ex, n_er, first_en, n_fa);
    chk_int("abort_pulses", n_en + n_ex + n_er, 0);
    chk("abort_busy", busy, 1'b0);

    // Short glitch on a, then an illegal 10 -> 01 jump, then a clean entry.
    hold(1, 0, 3);
    a = 0;
    watch(12, n_en, n_ex, n_er, first_en, n_fa);
    chk_int("glitch_fa_cycles", n_fa, 0);
    chk("glitch_busy", busy, 1'b0);
    hold(1, 0, 10);
    a = 0; b = 1;
    watch(12, n_en, n_ex, n_er, first_en, n_fa);
    chk_int("illegal_err_count", n_er, 1);
    chk("illegal_busy_held", busy, 1'b1);
    a = 0; b = 0;
    watch(12, n_en, n_ex, n_er, first_en, n_fa);
    chk("illegal_busy_clear", busy, 1'b0);
    chk_int("illegal_no_repeat", n_er, 0);
    hold(1, 0, 10); hold(1, 1, 10); hold(0, 1, 10);
    a = 0; b = 0;
    watch(14, n_en, n_ex, n_er, first_en, n_fa);
    chk_int("post_err_enter", n_en, 1);

    // Reset while in IN3 drops the pending entry.
    hold(1, 0, 10); hold(1, 1, 10); hold(0, 1, 10);
    chk("in3_busy", busy, 1'b1);
    reset = 1;
    @(negedge clk);
    reset = 0; a = 0; b = 0;
    watch(14, n_en, n_ex, n_er, first_en, n_fa);
    chk_int("midrst_enter", n_en, 0);
    chk_int("midrst_err", n_er, 0);
    chk("midrst_busy", busy, 1'b0);

    // Randomised legal walks with back-steps.
    for (int i = 0; i < 30; i++) walk($urandom_range(0, 1));

    // Random levels and glitches, with occasional resets.
    for (int i = 0; i < 250; i++) begin
      code = $urandom_range(0, 3);
      if ($urandom_range(0, 49) == 0) begin
        reset = 1;
        @(negedge clk);
        reset = 0;
      end
      hold(code[1], code[0], $urandom_range(1, 12));
    end
    hold(0, 0, 20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
